// File: rtl/hardware_top.sv
// Board I/O top: 8N1 UART transmit sequencer plus a receiver
// that fills eight byte registers in arrival order.
module hardware_top #(
  parameter int CLK_DIV   = 4,
  parameter int NUM_BYTES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] SB,
  output logic       TX,
  input  logic       RX,
  output logic [7:0] io_ena,
  output logic [7:0] io_0,
  output logic [7:0] io_1,
  output logic [7:0] io_2,
  output logic [7:0] io_3,
  output logic [7:0] io_4,
  output logic [7:0] io_5,
  output logic [7:0] io_6,
  output logic [7:0] io_7
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [3:0]    NB   = 4'(NUM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_st_t;

  function automatic logic [7:0] pat(
    input logic [3:0] k,
    input logic [7:0] sb
  );
    return sb ^ {k, k};
  endfunction

  logic          tx_run;
  logic [3:0]    tx_idx;
  logic [3:0]    tx_nxt;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    tx_sh;

  assign tx_nxt = tx_idx + 4'd1;

  // tx_bit: 0 start, 1..8 data, 9 stop, 10 inter-frame gap
  always_ff @(posedge CLK) begin
    if (!RST) begin
      TX     <= 1'b1;
      tx_run <= 1'b0;
      tx_idx <= '0;
      tx_bit <= '0;
      tx_cnt <= '0;
      tx_sh  <= '0;
    end else if (!tx_run) begin
      if (tx_idx < NB) begin
        tx_run <= 1'b1;
        TX     <= 1'b0;
        tx_bit <= '0;
        tx_cnt <= '0;
        tx_sh  <= pat(tx_idx, SB);
      end
    end else if (tx_cnt != LAST) begin
      tx_cnt <= tx_cnt + CW'(1);
    end else begin
      tx_cnt <= '0;
      if (tx_bit == 4'd10) begin
        tx_idx <= tx_nxt;
        if (tx_nxt < NB) begin
          TX     <= 1'b0;
          tx_bit <= '0;
          tx_sh  <= pat(tx_nxt, SB);
        end else begin
          tx_run <= 1'b0;
        end
      end else begin
        tx_bit <= tx_bit + 4'd1;
        if (tx_bit < 4'd8) begin
          TX    <= tx_sh[0];
          tx_sh <= {1'b0, tx_sh[7:1]};
        end else begin
          TX <= 1'b1;
        end
      end
    end
  end

  rx_st_t        rx_st;
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_err;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic [3:0]    wr_idx;
  logic [7:0]    io_r [8];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_st  <= IDLE;
      rx_err <= 1'b0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
      wr_idx <= '0;
      io_ena <= '0;
      for (int i = 0; i < 8; i++) io_r[i] <= '0;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      unique case (rx_st)
        IDLE: begin
          if (!rx_s2) begin
            rx_st  <= START;
            rx_cnt <= '0;
          end
        end
        START: begin
          if (rx_cnt == HALF) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        DATA: begin
          if (rx_cnt == LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        STOP: begin
          // after a framing error, hold off until the line goes idle
          if (rx_err) begin
            if (rx_s2) begin
              rx_err <= 1'b0;
              rx_st  <= IDLE;
            end
          end else if (rx_cnt == LAST) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_st <= IDLE;
              if (wr_idx < NB) begin
                io_r[wr_idx[2:0]]   <= rx_sh;
                io_ena[wr_idx[2:0]] <= 1'b1;
                wr_idx              <= wr_idx + 4'd1;
              end
            end else begin
              rx_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_st <= IDLE;
      endcase
    end
  end

  assign io_0 = io_r[0];
  assign io_1 = io_r[1];
  assign io_2 = io_r[2];
  assign io_3 = io_r[3];
  assign io_4 = io_r[4];
  assign io_5 = io_r[5];
  assign io_6 = io_r[6];
  assign io_7 = io_r[7];

endmodule

// File: tb/tb_hardware_top.sv
// Bench for hardware_top: loopback, TX waveform, reset,
// framing/glitch and saturation against a frame-level model.
module tb_hardware_top;

  localparam int D  = 4;
  localparam int FP = 11 * D;
  localparam int NB = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] SB  = 8'h00;
  logic       TX;
  logic       RX;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic [7:0] io_ena;
  logic [7:0] io [8];
  logic [7:0] sbf [8];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign RX = loop ? TX : rx_drv;

  hardware_top #(.CLK_DIV(D), .NUM_BYTES(NB)) dut (
    .CLK(CLK),
    .RST(RST),
    .SB(SB),
    .TX(TX),
    .RX(RX),
    .io_ena(io_ena),
    .io_0(io[0]),
    .io_1(io[1]),
    .io_2(io[2]),
    .io_3(io[3]),
    .io_4(io[4]),
    .io_5(io[5]),
    .io_6(io[6]),
    .io_7(io[7])
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return sbf[k] ^ 8'(k * 17);
  endfunction

  // expected TX after the n-th rising edge following reset release
  function automatic logic exp_tx(input int n);
    int k;
    int b;
    logic [7:0] d;
    k = n / FP;
    b = (n % FP) / D;
    if (k >= NB) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= 8) begin
      d = pat(k);
      return d[b-1];
    end
    return 1'b1;
  endfunction

  task automatic do_reset();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_tx", TX, 1);
    chk("rst_ena", io_ena, 0);
    for (int k = 0; k < NB; k++) chk("rst_io", io[k], 0);
    RST = 1'b1;
  endtask

  task automatic run(input int ncyc, input bit rnd, input bit lb);
    for (int n = 0; n < ncyc; n++) begin
      if (n % FP == 0 && n / FP < NB) sbf[n/FP] = SB;
      @(negedge CLK);
      chk("tx", TX, exp_tx(n));
      if (lb) begin
        for (int k = 0; k < NB; k++) begin
          if (n == k * FP + FP + 4) begin
            chk("lat_ena", io_ena[k], 1);
            chk("lat_io", io[k], pat(k));
          end
        end
      end
      if (rnd) SB = 8'($urandom);
    end
    if (lb) begin
      chk("end_ena", io_ena, 8'hFF);
      for (int k = 0; k < NB; k++) chk("end_io", io[k], pat(k));
    end else begin
      chk("end_ena0", io_ena, 0);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    repeat (D) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (D) @(negedge CLK);
    end
    rx_drv = stop;
    repeat (D) @(negedge CLK);
    rx_drv = 1'b1;
    repeat (3 * D) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] d;

    // loopback, SB=00
    loop = 1'b1;
    SB = 8'h00;
    do_reset();
    run(1000, 0, 1);
    chk("s1_io3", io[3], 8'h33);

    // loopback, SB=A5
    SB = 8'hA5;
    do_reset();
    run(400, 0, 1);
    chk("s2_io2", io[2], 8'h87);
    chk("s2_io7", io[7], 8'hD2);

    // loopback, random SB changing every cycle
    SB = 8'($urandom);
    do_reset();
    run(400, 1, 1);

    // TX waveform with RX held idle
    loop = 1'b0;
    rx_drv = 1'b1;
    SB = 8'h01;
    do_reset();
    run(400, 0, 0);

    // reset mid-operation
    loop = 1'b1;
    SB = 8'h00;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      @(negedge CLK);
      if (io_ena == 8'h07) break;
    end
    chk("mid_07", io_ena, 8'h07);
    do_reset();
    run(400, 0, 1);

    // framing error, glitch, then a valid byte
    loop = 1'b0;
    rx_drv = 1'b1;
    do_reset();
    send(8'h3C, 1'b0);
    chk("ferr_ena", io_ena, 0);
    chk("ferr_io0", io[0], 0);
    rx_drv = 1'b0;
    @(negedge CLK);
    rx_drv = 1'b1;
    repeat (3 * D) @(negedge CLK);
    chk("glitch_ena", io_ena, 0);
    send(8'h5A, 1'b1);
    chk("ok_io0", io[0], 8'h5A);
    chk("ok_ena", io_ena, 8'h01);
    chk("ok_io1", io[1], 0);

    // nine bytes, only eight stored
    do_reset();
    for (int i = 0; i < 9; i++) begin
      d = (i == 8) ? ~q[0] : 8'($urandom);
      q.push_back(d);
      send(d, 1'b1);
    end
    chk("sat_ena", io_ena, 8'hFF);
    for (int k = 0; k < NB; k++) chk("sat_io", io[k], q[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hardware_top.md
Name:
hardware_top

Overview:
- Board-level I/O top built around a UART (8N1) transmit sequencer and receiver, with eight 8-bit output registers.
- After reset, the TX sequencer sends eight bytes derived from the switch input SB.
- Each byte received on RX is stored in the next io register, and its enable bit is set.
- With TX looped back to RX, the block self-tests: the io registers fill with the transmitted pattern.

Parameters:
- CLK_DIV, 4: clock cycles per UART bit. Must be an even integer ≥ 4.
- NUM_BYTES, 8: number of bytes sent by the TX sequencer and number of io registers. Fixed at 8.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous reset, active-low.
- SB   input  8  switch bank; seeds the transmitted pattern.
- TX   output 1  UART serial out; idle high.
- RX   input  1  UART serial in; idle high.
- io_ena  output  8  bit k = io_k holds a valid received byte.
- io_0 … io_7  output  8 each  received-byte registers, in arrival order.

Behaviour:
- Reset (RST=0 sampled at a rising edge):
  - TX=1, io_ena=0, io_0..io_7=0.
  - TX byte index=0, RX write index=0; bit counters and divider cleared.
  - Any frame in progress (TX or RX) is aborted.
- TX sequencer:
  - On the first rising edge with RST=1, frame 0 starts and TX goes low.
  - Frame k (k=0..7): data = SB XOR (k × 8'h11), where SB is sampled at the frame's start edge.
  - Frame layout: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit is held exactly CLK_DIV cycles.
  - After each stop bit, TX idles high for CLK_DIV cycles before the next start bit.
  - Frame period = 11×CLK_DIV cycles (44 at default).
  - After frame 7, TX stays high permanently until the next reset.
  - SB changes during a frame affect only later frames.
- RX receiver:
  - States: IDLE, START, DATA, STOP.
  - IDLE → START on RX=0 (RX is synchronised through 2 flops first).
  - START: sample at CLK_DIV/2 cycles. If RX=1, treat as a glitch and return to IDLE. If RX=0, go to DATA.
  - DATA: 8 samples, each CLK_DIV cycles apart, shifted in LSB first.
  - STOP: sample one bit period later.
    - Stop bit =1: if write index <8, write the byte to io_[index], set io_ena[index], and increment the index. Return to IDLE.
    - Stop bit =0 (framing error): discard the byte; io registers and index unchanged. Return to IDLE once RX is high.
  - Write index saturates at 8; further valid bytes are ignored.
  - io_k and io_ena[k] update on the same edge and then hold until reset.
- Latency:
  - Each received byte is stored no later than 11×CLK_DIV+4 cycles after its start bit began on TX.
  - In loopback at default, all eight registers are valid within 8×44+8 = 360 cycles of reset release.
- No dependency between TX and RX beyond the external wire; RX accepts any conforming 8N1 stream at CLK_DIV cycles/bit.

Test Plan:
- Loopback (RX=TX), SB=8'h00, hold RST low 1 cycle then high, run 1000 cycles:
  - io_0..io_7 = 00,11,22,33,44,55,66,77.
  - io_ena=8'hFF.
  - TX=1 from cycle ~352 onward.
- Loopback, SB=8'hA5:
  - io_0..io_7 = A5,B4,87,96,E1,F0,C3,D2.
  - io_ena=FF.
- TX waveform check, SB=8'h01, RX tied high:
  - Frame 0: TX low 4 cycles, then high 4 cycles (bit0=1), then low 28 cycles (bits 1–7), then high for the stop bit.
  - Next start bit begins exactly 44 cycles after the first.
  - io_ena stays 00.
- Reset mid-operation:
  - Loopback; assert RST=0 for 1 cycle after io_ena=8'h07.
  - Immediately after: io_ena=00, all io=00, TX=1.
  - Sequence then restarts and ends with io_ena=FF and the pattern from scenario 1.
- RX framing error and glitch (RX driven by bench):
  - A frame with data 8'h3C and stop bit=0 → nothing stored.
  - A 1-cycle low pulse → nothing stored.
  - A following valid frame 8'h5A → io_0=5A, io_ena=01.
- Saturation:
  - Bench drives 9 valid RX bytes.
  - Only the first 8 are stored; the 9th is ignored; io_ena=FF.
